// File: rtl/rotate_tile_sched.sv
// Job sequencer for the image-rotate engine: validates a job, then walks 8x8 tiles in raster order,
// issuing one READ phase and one WRITE phase of DMA beats per tile.
module rotate_tile_sched #(
    parameter int unsigned BEATS_PER_PHASE = 64,
    parameter int unsigned MAX_HEIGHT      = 32767,
    parameter int unsigned MAX_WIDTH       = 16383
) (
    input  logic        I_HCLK,
    input  logic        I_HRESET_N,
    input  logic        I_START,
    input  logic        I_ABORT,
    input  logic [14:0] I_HEIGHT,
    input  logic [13:0] I_WIDTH,
    input  logic        I_DIRECTION,
    input  logic [2:0]  I_DEGREES,
    input  logic        I_DMA_READY,
    input  logic        I_DMA_ERROR,
    output logic        O_DMA_REQ,
    output logic        O_WRITE,
    output logic [5:0]  O_BEAT,
    output logic [10:0] O_TILE_X,
    output logic [11:0] O_TILE_Y,
    output logic        O_DIR_L,
    output logic [1:0]  O_DEG_L,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic        O_ERR,
    output logic [1:0]  O_ERR_CODE,
    output logic [2:0]  O_DBG_STATE
);

    // DMA handshake: O_DMA_REQ is the valid. A beat transfers on a cycle with O_DMA_REQ && I_DMA_READY
    // && !I_DMA_ERROR; until then REQ, O_WRITE, O_BEAT and the tile position are held stable.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [5:0]  LAST_BEAT = 6'(BEATS_PER_PHASE - 1);
    localparam logic [14:0] MAX_H     = 15'(MAX_HEIGHT);
    localparam logic [13:0] MAX_W     = 14'(MAX_WIDTH);

    state_t      state_q, state_d;
    logic [14:0] h_q, h_d;
    logic [13:0] w_q, w_d;
    logic [2:0]  deg_q, deg_d;
    logic        dir_q, dir_d;
    logic [11:0] tx_q, tx_d;
    logic [12:0] ty_q, ty_d;
    logic [5:0]  beat_q, beat_d;
    logic [10:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [1:0]  code_q, code_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        last_x, last_y, bad_dim;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        w_d     = w_q;
        deg_d   = deg_q;
        dir_d   = dir_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        beat_d  = beat_q;
        x_d     = x_q;
        y_d     = y_q;
        code_d  = code_q;
        last_x  = ({1'b0, x_q} == (tx_q - 12'd1));
        last_y  = ({1'b0, y_q} == (ty_q - 13'd1));
        bad_dim = (h_q == 15'd0) || (w_q == 14'd0) || (h_q > MAX_H) || (w_q > MAX_W);

        case (state_q)
            S_IDLE: begin
                if (I_START && !I_ABORT) begin
                    h_d     = I_HEIGHT;
                    w_d     = I_WIDTH;
                    deg_d   = I_DEGREES;
                    dir_d   = I_DIRECTION;
                    code_d  = 2'b00;
                    x_d     = '0;
                    y_d     = '0;
                    beat_d  = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Widened by one bit so W/H near the maximum cannot wrap before the shift.
                tx_d = 12'(({1'b0, w_q} + 15'd7) >> 3);
                ty_d = 13'(({1'b0, h_q} + 16'd7) >> 3);
                if (bad_dim) begin
                    code_d  = 2'b01;
                    state_d = S_ERR;
                end else if (deg_q > 3'd3) begin
                    code_d  = 2'b10;
                    state_d = S_ERR;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ, S_WRITE: begin
                if (I_DMA_ERROR) begin
                    code_d  = 2'b11;
                    state_d = S_ERR;
                end else if (I_DMA_READY) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = (state_q == S_READ) ? S_WRITE : S_NEXT;
                    end else begin
                        beat_d = beat_q + 6'd1;
                    end
                end
            end
            S_NEXT: begin
                if (last_x && last_y) begin
                    state_d = S_DONE;
                end else begin
                    if (last_x) begin
                        x_d = '0;
                        y_d = y_q + 12'd1;
                    end else begin
                        x_d = x_q + 11'd1;
                    end
                    state_d = S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a DMA error in the same cycle.
        if (state_q != S_IDLE && I_ABORT) begin
            state_d = S_IDLE;
            code_d  = 2'b00;
        end

        req_d  = (state_d == S_READ) || (state_d == S_WRITE);
        wr_d   = (state_d == S_WRITE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            w_q     <= '0;
            deg_q   <= '0;
            dir_q   <= 1'b0;
            tx_q    <= '0;
            ty_q    <= '0;
            beat_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            code_q  <= '0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            w_q     <= w_d;
            deg_q   <= deg_d;
            dir_q   <= dir_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            beat_q  <= beat_d;
            x_q     <= x_d;
            y_q     <= y_d;
            code_q  <= code_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign O_DMA_REQ   = req_q;
    assign O_WRITE     = wr_q;
    assign O_BEAT      = beat_q;
    assign O_TILE_X    = x_q;
    assign O_TILE_Y    = y_q;
    assign O_DIR_L     = dir_q;
    assign O_DEG_L     = deg_q[1:0];
    assign O_BUSY      = busy_q;
    assign O_DONE      = done_q;
    assign O_ERR       = err_q;
    assign O_ERR_CODE  = code_q;
    assign O_DBG_STATE = state_q;

endmodule
